// File: rtl/vec_pkg.sv
// Shared constants, helpers and serializer state encoding for the chunked vector datapath.
package vec_pkg;

  localparam int unsigned WIDTH_D    = 32;
  localparam int unsigned SIZE_D     = 16;
  localparam int unsigned COMBSIZE_D = 4;

  function automatic int unsigned nbeats(input int unsigned size, input int unsigned combsize);
    return size / combsize;
  endfunction

  // Index/extension widths never collapse to zero bits.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/vector_chunk_sum.sv
// Combinational signed sum of the COMBSIZE elements of one chunk, full-precision result.
module vector_chunk_sum
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_D,
  parameter int unsigned COMBSIZE = COMBSIZE_D
) (
  input  logic [WIDTH*COMBSIZE-1:0]                       chunk,
  output logic signed [WIDTH+clog2_safe(COMBSIZE)-1:0]   sum_c
);

  localparam int unsigned SUMW = WIDTH + clog2_safe(COMBSIZE);

  always_comb begin
    sum_c = '0;
    for (int j = 0; j < int'(COMBSIZE); j++) begin
      sum_c = sum_c + SUMW'($signed(chunk[WIDTH*j +: WIDTH]));
    end
  end

endmodule

// File: rtl/vector_chunk_serializer.sv
// Captures one SIZE-element vector and streams it as COMBSIZE-element beats, lowest chunk first.
// Optional running inclusive chunk sum on out_sum when VEC_SER_SUM_EN is defined.
module vector_chunk_serializer
  import vec_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_D,
  parameter int unsigned SIZE     = SIZE_D,
  parameter int unsigned COMBSIZE = COMBSIZE_D
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH*SIZE-1:0]                    in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WIDTH*COMBSIZE-1:0]                out_data,
  output logic [clog2_safe(SIZE/COMBSIZE)-1:0]     out_idx,
  output logic                                     out_last
`ifdef VEC_SER_SUM_EN
  ,
  output logic signed [WIDTH+clog2_safe(SIZE)-1:0] out_sum
`endif
);

  localparam int unsigned NBEATS = nbeats(SIZE, COMBSIZE);
  localparam int unsigned IDXW   = clog2_safe(NBEATS);
  localparam int unsigned CHUNKW = WIDTH * COMBSIZE;
  localparam int unsigned VECW   = WIDTH * SIZE;

  if (SIZE % COMBSIZE != 0) begin : g_bad_cfg
    $error("SIZE must be an exact multiple of COMBSIZE");
  end

  ser_state_t        state, state_n;
  logic [IDXW-1:0]   beat_n;
  logic [VECW-1:0]   vec_q, vec_n;
  logic [CHUNKW-1:0] chunk_n;
  logic              last_n;
  logic              in_fire_c, out_fire_c;

  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;

  // Next state, beat index and captured vector; outputs are loaded from the next values.
  always_comb begin
    state_n = state;
    beat_n  = out_idx;
    vec_n   = vec_q;
    case (state)
      IDLE: begin
        if (in_fire_c) begin
          vec_n   = in_data;
          beat_n  = '0;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (out_fire_c) begin
          if (out_idx == IDXW'(NBEATS - 1)) begin
            beat_n  = '0;
            state_n = IDLE;
          end else begin
            beat_n = out_idx + IDXW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    chunk_n = (state_n == STREAM) ? vec_n[CHUNKW*beat_n +: CHUNKW] : '0;
    last_n  = (state_n == STREAM) && (beat_n == IDXW'(NBEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      vec_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      vec_q     <= vec_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == STREAM);
      out_data  <= chunk_n;
      out_idx   <= beat_n;
      out_last  <= last_n;
    end
  end

`ifdef VEC_SER_SUM_EN
  localparam int unsigned SUMW  = WIDTH + clog2_safe(SIZE);
  localparam int unsigned TREEW = WIDTH + clog2_safe(COMBSIZE);

  logic signed [TREEW-1:0] chunk_sum_c;
  logic signed [SUMW-1:0]  acc, acc_n;

  vector_chunk_sum #(
    .WIDTH    (WIDTH),
    .COMBSIZE (COMBSIZE)
  ) u_chunk_sum (
    .chunk (chunk_n),
    .sum_c (chunk_sum_c)
  );

  // out_sum already holds acc plus the current chunk, so it becomes the new acc on a beat.
  always_comb begin
    acc_n = acc;
    if (in_fire_c) begin
      acc_n = '0;
    end else if (out_fire_c) begin
      acc_n = out_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      out_sum <= '0;
    end else begin
      acc     <= acc_n;
      out_sum <= (state_n == STREAM) ? acc_n + SUMW'(chunk_sum_c) : '0;
    end
  end
`endif

endmodule
